// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline stall/flush sequencer.
// StallBus width and Stop/NoStop encodings, the per-source stall masks,
// the sequencer state encoding and the stall-priority helper functions.
package pipe_ctrl_pkg;

   localparam int STALL_W = 6;

   // One bit per stage register: Stop holds the register, NoStop lets it load.
   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   typedef logic [STALL_W-1:0] stall_bus_t;

   // Each mask freezes the requesting stage and every older-PC stage and
   // bubbles the next stage down the pipe.
   localparam stall_bus_t STALL_NONE = {STALL_W{NO_STOP}};
   localparam stall_bus_t MASK_IF    = 6'b000011;
   localparam stall_bus_t MASK_LOAD  = 6'b000111;
   localparam stall_bus_t MASK_EX    = 6'b001111;
   localparam stall_bus_t MASK_MEM   = 6'b011111;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FLUSH = 2'd2
   } pipe_state_e;

   typedef enum logic [2:0] {
      SRC_NONE = 3'd0,
      SRC_IF   = 3'd1,
      SRC_LOAD = 3'd2,
      SRC_EX   = 3'd3,
      SRC_MEM  = 3'd4
   } stall_src_e;

   // Youngest requesting stage wins: its mask already covers the older ones.
   function automatic stall_src_e win_src(input logic req_if, input logic req_load,
                                          input logic req_ex, input logic req_mem);
      stall_src_e s;
      if (req_mem)       s = SRC_MEM;
      else if (req_ex)   s = SRC_EX;
      else if (req_load) s = SRC_LOAD;
      else if (req_if)   s = SRC_IF;
      else               s = SRC_NONE;
      return s;
   endfunction

   function automatic stall_bus_t src_mask(input stall_src_e s);
      stall_bus_t m;
      case (s)
         SRC_MEM:  m = MASK_MEM;
         SRC_EX:   m = MASK_EX;
         SRC_LOAD: m = MASK_LOAD;
         SRC_IF:   m = MASK_IF;
         default:  m = STALL_NONE;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle between the pipeline stages and the stall/flush
// sequencer. Stages raise level stall requests and a one-cycle flush_req
// pulse (with flush_pc); the sequencer returns the StallBus, a one-cycle
// flush pulse with new_pc, the sticky watchdog flag and its state for
// observation. There is no back-pressure: every signal is sampled on each
// rising clock edge. perf_bus exists only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic        stallreq_for_if;
   logic        stallreq_for_load;
   logic        stallreq_for_ex;
   logic        stallreq_for_mem;
   logic        flush_req;
   logic [31:0] flush_pc;
   stall_bus_t  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        stall_timeout;
   pipe_state_e state;
`ifdef PIPE_CTRL_PERF_EN
   logic [159:0] perf_bus;
`endif

`ifdef PIPE_CTRL_PERF_EN
   modport master (
      output stallreq_for_if, stallreq_for_load, stallreq_for_ex, stallreq_for_mem,
      output flush_req, flush_pc,
      input  stall, flush, new_pc, stall_timeout, state, perf_bus
   );
   modport slave (
      input  stallreq_for_if, stallreq_for_load, stallreq_for_ex, stallreq_for_mem,
      input  flush_req, flush_pc,
      output stall, flush, new_pc, stall_timeout, state, perf_bus
   );
`else
   modport master (
      output stallreq_for_if, stallreq_for_load, stallreq_for_ex, stallreq_for_mem,
      output flush_req, flush_pc,
      input  stall, flush, new_pc, stall_timeout, state
   );
   modport slave (
      input  stallreq_for_if, stallreq_for_load, stallreq_for_ex, stallreq_for_mem,
      input  flush_req, flush_pc,
      output stall, flush, new_pc, stall_timeout, state
   );
`endif

endinterface

// File: rtl/pipe_ctrl_wdog.sv
// pipe_ctrl_wdog: saturating consecutive-activity counter with a sticky
// timeout flag. Counts every cycle active_i is high, clears on any idle
// cycle, and latches timeout_o once the count reaches MAX (until reset).
module pipe_ctrl_wdog #(
   parameter int         W   = 16,
   parameter logic [W-1:0] MAX = {W{1'b1}}
) (
   input  logic clk,
   input  logic resetn,
   input  logic active_i,
   output logic timeout_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         flag_q, flag_d;

   // Next count saturates at MAX; the flag sets the same edge the count gets there.
   always_comb begin
      cnt_d  = '0;
      if (active_i) begin
         cnt_d = (cnt_q == MAX) ? MAX : cnt_q + 1'b1;
      end
      flag_d = flag_q | (cnt_d == MAX);
   end

   // Counter and sticky flag registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
      end
   end

   assign timeout_o = flag_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Merges stage stall requests into the StallBus, sequences exception/eret
// flushes (deferred while MEM is blocked, oldest request wins) and runs a
// stall watchdog. Optional macro PIPE_CTRL_PERF_EN adds per-source stall
// counters and a flush counter on perf_bus.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int                WDOG_W   = 16,
   parameter logic [WDOG_W-1:0] WDOG_MAX = {WDOG_W{1'b1}}
) (
   input logic          clk,
   input logic          resetn,
   pipe_ctrl_if.slave   bus
);

   pipe_state_e state_q;
   logic        flush_q;
   logic [31:0] new_pc_q;
   logic [31:0] pend_pc_q;
   stall_src_e  src_raw;
   stall_src_e  src;
   stall_bus_t  stall_d;
   logic        timeout;

   // Winning stall source; nothing stalls during the flush cycle or in reset.
   always_comb begin
      src_raw = win_src(bus.stallreq_for_if, bus.stallreq_for_load,
                        bus.stallreq_for_ex, bus.stallreq_for_mem);
      src     = SRC_NONE;
      if (resetn && (state_q != ST_FLUSH)) begin
         src = src_raw;
      end
      stall_d = src_mask(src);
   end

   // Flush sequencer: RUN accepts a request, WAIT holds it behind a MEM stall,
   // FLUSH drives the one-cycle redirect. Outputs are registered here.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_RUN;
         flush_q   <= 1'b0;
         new_pc_q  <= '0;
         pend_pc_q <= '0;
      end else begin
         flush_q <= 1'b0;
         case (state_q)
            ST_RUN: begin
               if (bus.flush_req) begin
                  pend_pc_q <= bus.flush_pc;
                  if (bus.stallreq_for_mem) begin
                     state_q <= ST_WAIT;
                  end else begin
                     state_q  <= ST_FLUSH;
                     flush_q  <= 1'b1;
                     new_pc_q <= bus.flush_pc;
                  end
               end
            end
            ST_WAIT: begin
               // Later flush_req pulses are dropped: the older exception wins.
               if (!bus.stallreq_for_mem) begin
                  state_q  <= ST_FLUSH;
                  flush_q  <= 1'b1;
                  new_pc_q <= pend_pc_q;
               end
            end
            ST_FLUSH: begin
               state_q <= ST_RUN;
            end
            default: begin
               state_q <= ST_RUN;
            end
         endcase
      end
   end

   pipe_ctrl_wdog #(
      .W   (WDOG_W),
      .MAX (WDOG_MAX)
   ) u_wdog (
      .clk       (clk),
      .resetn    (resetn),
      .active_i  (stall_d != STALL_NONE),
      .timeout_o (timeout)
   );

   assign bus.stall         = stall_d;
   assign bus.flush         = flush_q;
   assign bus.new_pc        = new_pc_q;
   assign bus.stall_timeout = timeout;
   assign bus.state         = state_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] cnt_mem_q, cnt_ex_q, cnt_load_q, cnt_if_q, cnt_flush_q;

   // Wrapping event counters: one per winning stall source plus flush cycles.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_mem_q   <= '0;
         cnt_ex_q    <= '0;
         cnt_load_q  <= '0;
         cnt_if_q    <= '0;
         cnt_flush_q <= '0;
      end else begin
         if (src == SRC_MEM)  cnt_mem_q  <= cnt_mem_q + 1'b1;
         if (src == SRC_EX)   cnt_ex_q   <= cnt_ex_q + 1'b1;
         if (src == SRC_LOAD) cnt_load_q <= cnt_load_q + 1'b1;
         if (src == SRC_IF)   cnt_if_q   <= cnt_if_q + 1'b1;
         if (flush_q)         cnt_flush_q <= cnt_flush_q + 1'b1;
      end
   end

   assign bus.perf_bus = {cnt_mem_q, cnt_ex_q, cnt_load_q, cnt_if_q, cnt_flush_q};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed table of stall-request vectors plus hand-written
// flush, deferred-flush, watchdog and reset sequences for pipe_ctrl.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   logic clk = 1'b0;
   logic resetn = 1'b0;

   always #5 clk = ~clk;

   pipe_ctrl_if bus ();

   pipe_ctrl #(
      .WDOG_W   (16),
      .WDOG_MAX (16'd8)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct {
      logic       r_if;
      logic       r_load;
      logic       r_ex;
      logic       r_mem;
      logic [5:0] exp_stall;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic i, input logic l, input logic e, input logic m,
                         input logic fr, input logic [31:0] pc);
      bus.stallreq_for_if   = i;
      bus.stallreq_for_load = l;
      bus.stallreq_for_ex   = e;
      bus.stallreq_for_mem  = m;
      bus.flush_req         = fr;
      bus.flush_pc          = pc;
   endtask

   initial begin
      // Vector table: each source alone, then combinations; stall runs stay short.
      vecs[0]  = '{1,0,0,0, 6'b000011};
      vecs[1]  = '{1,0,0,0, 6'b000011};
      vecs[2]  = '{1,0,0,0, 6'b000011};
      vecs[3]  = '{0,0,0,0, 6'b000000};
      vecs[4]  = '{0,1,0,0, 6'b000111};
      vecs[5]  = '{0,1,0,0, 6'b000111};
      vecs[6]  = '{0,1,0,0, 6'b000111};
      vecs[7]  = '{0,0,0,0, 6'b000000};
      vecs[8]  = '{0,0,1,0, 6'b001111};
      vecs[9]  = '{0,0,1,0, 6'b001111};
      vecs[10] = '{0,0,1,0, 6'b001111};
      vecs[11] = '{0,0,0,0, 6'b000000};
      vecs[12] = '{0,0,0,1, 6'b011111};
      vecs[13] = '{0,0,0,1, 6'b011111};
      vecs[14] = '{0,0,0,1, 6'b011111};
      vecs[15] = '{0,0,0,0, 6'b000000};
      vecs[16] = '{0,1,0,1, 6'b011111};
      vecs[17] = '{0,1,0,0, 6'b000111};
      vecs[18] = '{0,0,0,0, 6'b000000};
      vecs[19] = '{1,1,1,1, 6'b011111};
      vecs[20] = '{1,0,1,0, 6'b001111};
      vecs[21] = '{0,1,1,0, 6'b001111};

      // Reset state
      set_in(0, 0, 0, 0, 0, 32'h0);
      #12;
      chk("rst stall", {26'd0, bus.stall}, 32'd0);
      chk("rst flush", {31'd0, bus.flush}, 32'd0);
      chk("rst new_pc", bus.new_pc, 32'd0);
      chk("rst timeout", {31'd0, bus.stall_timeout}, 32'd0);
      chk("rst state", {30'd0, bus.state}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      // Table-driven stall masks
      for (int k = 0; k < NV; k++) begin
         @(negedge clk);
         set_in(vecs[k].r_if, vecs[k].r_load, vecs[k].r_ex, vecs[k].r_mem, 1'b0, 32'h0);
         #1;
         chk($sformatf("vec%0d stall", k), {26'd0, bus.stall}, {26'd0, vecs[k].exp_stall});
         chk($sformatf("vec%0d flush", k), {31'd0, bus.flush}, 32'd0);
      end
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 32'h0);
      #1;
      chk("table timeout", {31'd0, bus.stall_timeout}, 32'd0);

      // Direct flush, no stalls
      @(negedge clk);
      set_in(0, 0, 0, 0, 1, 32'hBFC00380);
      #1;
      chk("fl0 req flush", {31'd0, bus.flush}, 32'd0);
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 32'h0);
      #1;
      chk("fl0 flush", {31'd0, bus.flush}, 32'd1);
      chk("fl0 new_pc", bus.new_pc, 32'hBFC00380);
      chk("fl0 stall", {26'd0, bus.stall}, 32'd0);
      chk("fl0 state", {30'd0, bus.state}, 32'd2);
      @(negedge clk);
      #1;
      chk("fl0 after flush", {31'd0, bus.flush}, 32'd0);
      chk("fl0 after new_pc", bus.new_pc, 32'hBFC00380);
      chk("fl0 after state", {30'd0, bus.state}, 32'd0);

      // Flush alongside a load stall; requests during FLUSH ignored
      @(negedge clk);
      set_in(0, 1, 0, 0, 1, 32'h12345678);
      #1;
      chk("fl1 req stall", {26'd0, bus.stall}, 32'h07);
      chk("fl1 req flush", {31'd0, bus.flush}, 32'd0);
      @(negedge clk);
      set_in(0, 0, 1, 0, 1, 32'hDEADBEEF);
      #1;
      chk("fl1 flush", {31'd0, bus.flush}, 32'd1);
      chk("fl1 new_pc", bus.new_pc, 32'h12345678);
      chk("fl1 forced stall", {26'd0, bus.stall}, 32'd0);
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 32'h0);
      #1;
      chk("fl1 after flush", {31'd0, bus.flush}, 32'd0);
      chk("fl1 after new_pc", bus.new_pc, 32'h12345678);
      chk("fl1 after state", {30'd0, bus.state}, 32'd0);
      @(negedge clk);
      #1;
      chk("fl1 ignored req", {31'd0, bus.flush}, 32'd0);

      // Flush deferred behind a 4-cycle mem stall; second request dropped
      @(negedge clk);
      set_in(0, 0, 0, 1, 1, 32'hBFC00380);
      #1;
      chk("wt c0 stall", {26'd0, bus.stall}, 32'h1F);
      chk("wt c0 flush", {31'd0, bus.flush}, 32'd0);
      @(negedge clk);
      set_in(0, 0, 0, 1, 1, 32'h80000000);
      #1;
      chk("wt c1 state", {30'd0, bus.state}, 32'd1);
      chk("wt c1 stall", {26'd0, bus.stall}, 32'h1F);
      chk("wt c1 flush", {31'd0, bus.flush}, 32'd0);
      for (int c = 2; c < 4; c++) begin
         @(negedge clk);
         set_in(0, 0, 0, 1, 0, 32'h0);
         #1;
         chk($sformatf("wt c%0d flush", c), {31'd0, bus.flush}, 32'd0);
         chk($sformatf("wt c%0d state", c), {30'd0, bus.state}, 32'd1);
      end
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 32'h0);
      #1;
      chk("wt c4 stall", {26'd0, bus.stall}, 32'd0);
      chk("wt c4 flush", {31'd0, bus.flush}, 32'd0);
      @(negedge clk);
      #1;
      chk("wt c5 flush", {31'd0, bus.flush}, 32'd1);
      chk("wt c5 new_pc", bus.new_pc, 32'hBFC00380);
      for (int c = 6; c < 9; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("wt c%0d flush", c), {31'd0, bus.flush}, 32'd0);
         chk($sformatf("wt c%0d new_pc", c), bus.new_pc, 32'hBFC00380);
      end

      // Watchdog: ex stall for 10 cycles with WDOG_MAX=8
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         set_in(0, 0, 1, 0, 0, 32'h0);
         #1;
         chk($sformatf("wd cyc%0d timeout", k), {31'd0, bus.stall_timeout},
             (k >= 9) ? 32'd1 : 32'd0);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         set_in(0, 0, 0, 0, 0, 32'h0);
         #1;
         chk($sformatf("wd sticky%0d", k), {31'd0, bus.stall_timeout}, 32'd1);
      end
      #2;
      resetn = 1'b0;
      #1;
      chk("wd rst timeout", {31'd0, bus.stall_timeout}, 32'd0);
      chk("wd rst new_pc", bus.new_pc, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      // Reset while a flush waits behind a mem stall
      @(negedge clk);
      set_in(0, 0, 0, 1, 1, 32'hCAFE0000);
      #1;
      @(negedge clk);
      set_in(0, 0, 0, 1, 0, 32'h0);
      #1;
      chk("rw wait state", {30'd0, bus.state}, 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      chk("rw async stall", {26'd0, bus.stall}, 32'd0);
      chk("rw async state", {30'd0, bus.state}, 32'd0);
      chk("rw async flush", {31'd0, bus.flush}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      set_in(0, 0, 0, 0, 0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rw post flush%0d", k), {31'd0, bus.flush}, 32'd0);
         chk($sformatf("rw post state%0d", k), {30'd0, bus.state}, 32'd0);
      end
      chk("rw post new_pc", bus.new_pc, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB).
- Merges per-stage stall requests (IF sram wait, ID load-use, EX multi-cycle op, MEM sram wait) into the StallBus consumed by every stage register.
- Sequences pipeline flushes (exception/eret redirect), deferring them while the MEM stage is blocked.
- Runs a stall watchdog.

Parameters:
STALL_W, 6, width of stall bus; bit i = stage register i held (1 = Stop, 0 = NoStop).
WDOG_W, 16, width of consecutive-stall counter.
WDOG_MAX, 16'hFFFF, consecutive stalled cycles that trip stall_timeout.

Ports:
clk  in  1  pipeline clock, rising edge.
resetn  in  1  asynchronous, active-low reset.
stallreq_for_if  in  1  inst sram not ready.
stallreq_for_load  in  1  ID load-use hazard.
stallreq_for_ex  in  1  EX multi-cycle unit busy.
stallreq_for_mem  in  1  data sram not ready.
flush_req  in  1  MEM-stage exception/eret; one-cycle pulse.
flush_pc  in  32  redirect target, valid with flush_req.
stall  out  STALL_W  per-stage hold vector.
flush  out  1  clear all stage registers; one-cycle pulse.
new_pc  out  32  redirect PC, valid while flush=1.
stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (resetn=0, async):
  - State is RUN.
  - stall=0, flush=0, new_pc=0, stall_timeout=0, watchdog counter=0, pending pc=0.
- Stall masks, combinational in RUN and WAIT. Highest active request wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - load → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
  - Each mask freezes the requesting stage and all older-PC stages, and inserts a bubble into the next stage.
- State machine:
  - RUN:
    - flush_req=1 with stallreq_for_mem=0: latch flush_pc, go to FLUSH.
    - flush_req=1 with stallreq_for_mem=1: latch flush_pc, go to WAIT.
  - WAIT:
    - Stall mask still applies.
    - Further flush_req pulses are ignored; the first (oldest) flush wins.
    - Go to FLUSH in the first cycle stallreq_for_mem=0.
  - FLUSH (exactly one cycle):
    - flush=1, new_pc=latched pc, stall forced to 0.
    - All stall requests and flush_req in this cycle are ignored.
    - Next state RUN.
- Latency:
  - flush_req sampled at edge N with no mem stall → flush=1 during cycle N+1.
  - flush, new_pc and state are registered; stall is combinational.
- Outside FLUSH, new_pc holds its last value and flush=0.
- Watchdog:
  - Counter increments each cycle stall≠0; clears on any cycle stall=0.
  - Saturates at WDOG_MAX.
  - On reaching WDOG_MAX, stall_timeout is set and held until reset.
- Simultaneous flush_req and stall requests in RUN: the stall mask applies in that cycle; the flush is accepted per the mem rule.
- Reset asserted mid-WAIT or mid-FLUSH: pending flush is discarded; all outputs return to reset values immediately.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined:
  - Adds four 32-bit wrapping counters, one per stall source. Each increments on cycles where its source is the winning stall.
  - Adds a 32-bit flush counter.
  - Adds output perf_bus (160 bits, order mem, ex, load, if, flush).
  - All counters reset to 0.
- Undefined: no counters and no perf_bus port; behaviour is otherwise identical.

Decomposition:
- Shared defines header holds:
  - StallBus width and the Stop/NoStop encodings.
  - The four stall masks as named constants.
  - The state encoding: RUN=2'd0, WAIT=2'd1, FLUSH=2'd2.
- One natural sub-module: pipe_ctrl_wdog (saturating counter plus sticky flag), reusable for sram handshake timeouts.

Test Plan:
- Each request alone for 3 cycles (if, load, ex, mem) → stall = 000011 / 000111 / 001111 / 011111 each cycle; 000000 afterwards.
- load=1 and mem=1 together → stall=011111; drop mem → 000111 the same cycle.
- flush_req with flush_pc=32'hBFC00380, no stalls → next cycle flush=1, new_pc=BFC00380, stall=0; following cycle flush=0.
- mem stall held 4 cycles, flush_req(BFC00380) in cycle 1, flush_req(80000000) in cycle 2 → flush=1 with new_pc=BFC00380 one cycle after mem drops; second request never produces a flush.
- WDOG_MAX=8, ex stall held 10 cycles → stall_timeout rises after the 8th stalled cycle and stays 1 after the stall drops, until resetn=0.
- resetn pulsed low while in WAIT → outputs zero asynchronously; after release, no flush occurs.
